// File: rtl/dmc_bank_arbiter_if.sv
// Request/response bundle for two requesters plus the A/B memory-bank command ports.
// slave = arbiter side, master = requesters and memory models.
interface dmc_bank_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              r0_valid, r0_ready, r0_we, r0_bank, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_valid, r1_ready, r1_we, r1_bank, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic              mema_en, mema_we, memb_en, memb_we;
  logic [ADDR_W-1:0] mema_addr, memb_addr;
  logic [DATA_W-1:0] mema_wdata, mema_rdata, memb_wdata, memb_rdata;

  modport slave (
    input  r0_valid, r0_we, r0_bank, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_bank, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output mema_en, mema_we, mema_addr, mema_wdata,
    input  mema_rdata,
    output memb_en, memb_we, memb_addr, memb_wdata,
    input  memb_rdata
  );

  modport master (
    output r0_valid, r0_we, r0_bank, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_bank, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mema_en, mema_we, mema_addr, mema_wdata,
    output mema_rdata,
    input  memb_en, memb_we, memb_addr, memb_wdata,
    output memb_rdata
  );
endinterface

// File: rtl/dmc_bank_arbiter.sv
// Two-requester / two-bank arbiter with per-bank round-robin, registered bank commands
// and read-data routing. Optional DMC_PERF_CNT_EN adds saturating grant/conflict counters.
module dmc_bank_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BANK_A = 0
) (
  input  logic clk,
  input  logic rst,
  dmc_bank_arbiter_if.slave bus
`ifdef DMC_PERF_CNT_EN
  ,
  output logic [15:0] o_r0_grant_cnt,
  output logic [15:0] o_r1_grant_cnt,
  output logic [15:0] o_conflict_cnt
`endif
);

  localparam logic BANK_A_BIT = 1'(BANK_A);

  // Requester-indexed views of the port signals; index 0 = bank A / R0
  logic [1:0]        w_valid, w_we, w_tgt, w_ready, w_pend, w_pown;
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic [DATA_W-1:0] w_mem_rdata [2];
  logic [1:0]        w_cont [2];
  logic [1:0]        w_gnt [2];

  assign w_valid        = {bus.r1_valid, bus.r0_valid};
  assign w_we           = {bus.r1_we, bus.r0_we};
  assign w_tgt          = {bus.r1_bank != BANK_A_BIT, bus.r0_bank != BANK_A_BIT};
  assign w_addr[0]      = bus.r0_addr;
  assign w_addr[1]      = bus.r1_addr;
  assign w_wdata[0]     = bus.r0_wdata;
  assign w_wdata[1]     = bus.r1_wdata;
  assign w_mem_rdata[0] = bus.mema_rdata;
  assign w_mem_rdata[1] = bus.memb_rdata;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_bank
    logic              r_last_grant, r_en, r_we, r_owner, r_pend, r_pown;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_sel;

    assign w_cont[gi] = {w_valid[1] && (w_tgt[1] == 1'(gi)),
                         w_valid[0] && (w_tgt[0] == 1'(gi))};
    // On contention the requester that did not win last time gets the bank
    assign w_gnt[gi]  = {w_cont[gi][1] && (!w_cont[gi][0] || !r_last_grant),
                         w_cont[gi][0] && (!w_cont[gi][1] ||  r_last_grant)};
    assign w_sel      = w_gnt[gi][1];
    assign w_pend[gi] = r_pend;
    assign w_pown[gi] = r_pown;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_last_grant <= 1'b1;
        r_en         <= 1'b0;
        r_we         <= 1'b0;
        r_owner      <= 1'b0;
        r_addr       <= '0;
        r_wdata      <= '0;
        r_pend       <= 1'b0;
        r_pown       <= 1'b0;
      end else begin
        if (|w_gnt[gi]) begin
          r_last_grant <= w_sel;
          r_en         <= 1'b1;
          r_we         <= w_we[w_sel];
          r_addr       <= w_addr[w_sel];
          r_wdata      <= w_wdata[w_sel];
          r_owner      <= w_sel;
        end else begin
          r_en <= 1'b0;
          r_we <= 1'b0;
        end
        // Memory samples the command this edge; its read data is valid next cycle
        r_pend <= r_en && !r_we;
        r_pown <= r_owner;
      end
    end
  end

  for (gi = 0; gi < 2; gi++) begin : g_req
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              w_hit_a, w_hit_b;

    assign w_hit_a     = w_pend[0] && (w_pown[0] == 1'(gi));
    assign w_hit_b     = w_pend[1] && (w_pown[1] == 1'(gi));
    assign w_ready[gi] = !rst && w_gnt[w_tgt[gi]][gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_hit_a || w_hit_b;
        if (w_hit_a)
          r_rdata <= w_mem_rdata[0];
        else if (w_hit_b)
          r_rdata <= w_mem_rdata[1];
      end
    end
  end

  assign bus.r0_ready   = w_ready[0];
  assign bus.r1_ready   = w_ready[1];
  assign bus.r0_rvalid  = g_req[0].r_rvalid;
  assign bus.r0_rdata   = g_req[0].r_rdata;
  assign bus.r1_rvalid  = g_req[1].r_rvalid;
  assign bus.r1_rdata   = g_req[1].r_rdata;
  assign bus.mema_en    = g_bank[0].r_en;
  assign bus.mema_we    = g_bank[0].r_we;
  assign bus.mema_addr  = g_bank[0].r_addr;
  assign bus.mema_wdata = g_bank[0].r_wdata;
  assign bus.memb_en    = g_bank[1].r_en;
  assign bus.memb_we    = g_bank[1].r_we;
  assign bus.memb_addr  = g_bank[1].r_addr;
  assign bus.memb_wdata = g_bank[1].r_wdata;

`ifdef DMC_PERF_CNT_EN
  logic [15:0] r_r0_grant_cnt, r_r1_grant_cnt, r_conflict_cnt;
  logic        w_conflict;

  assign w_conflict = (&w_cont[0]) || (&w_cont[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r0_grant_cnt <= '0;
      r_r1_grant_cnt <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_ready[0] && (r_r0_grant_cnt != 16'hFFFF)) r_r0_grant_cnt <= r_r0_grant_cnt + 16'd1;
      if (w_ready[1] && (r_r1_grant_cnt != 16'hFFFF)) r_r1_grant_cnt <= r_r1_grant_cnt + 16'd1;
      if (w_conflict && (r_conflict_cnt != 16'hFFFF)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign o_r0_grant_cnt = r_r0_grant_cnt;
  assign o_r1_grant_cnt = r_r1_grant_cnt;
  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmc_bank_arbiter.sv
// Directed, table-driven bench for dmc_bank_arbiter with behavioural bank memories.
// Memory content at start: A[i] = i + 8'h30, B[i] = i + 8'h80.
module tb_dmc_bank_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmc_bank_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

`ifdef DMC_PERF_CNT_EN
  logic [15:0] r0_cnt, r1_cnt, cf_cnt;
  dmc_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .BANK_A(0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .o_r0_grant_cnt(r0_cnt), .o_r1_grant_cnt(r1_cnt), .o_conflict_cnt(cf_cnt));
`else
  dmc_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .BANK_A(0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'(i + 8'h30);
        mem_b[i] <= 8'(i + 8'h80);
      end
    end else begin
      if (bus.mema_en) begin
        if (bus.mema_we) mem_a[bus.mema_addr] <= bus.mema_wdata;
        else             bus.mema_rdata <= mem_a[bus.mema_addr];
      end
      if (bus.memb_en) begin
        if (bus.memb_we) mem_b[bus.memb_addr] <= bus.memb_wdata;
        else             bus.memb_rdata <= mem_b[bus.memb_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, we0, bk0, input logic [7:0] ad0, wd0,
                       input logic v1, we1, bk1, input logic [7:0] ad1, wd1);
    bus.r0_valid = v0; bus.r0_we = we0; bus.r0_bank = bk0; bus.r0_addr = ad0; bus.r0_wdata = wd0;
    bus.r1_valid = v1; bus.r1_we = we1; bus.r1_bank = bk1; bus.r1_addr = ad1; bus.r1_wdata = wd1;
  endtask

  typedef struct {
    logic       v0, we0, bk0; logic [7:0] ad0, wd0;
    logic       v1, we1, bk1; logic [7:0] ad1, wd1;
    logic       rdy0, rdy1, aen, awe; logic [7:0] aaddr, awdata;
    logic       ben, rv0; logic [7:0] rd0; logic rv1; logic [7:0] rd1;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            R0: v we bk addr  wdata   R1: v we bk addr  wdata  rdy0 rdy1 aen awe aaddr awdata ben rv0 rd0  rv1 rd1
    vecs[0]  = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 0,0,8'h00,8'h00, 0, 0,8'h00, 0,8'h00};
    vecs[1]  = '{1,1,0,8'h10,8'h5A, 0,0,0,8'h00,8'h00, 1,0, 0,0,8'h00,8'h00, 0, 0,8'h00, 0,8'h00};
    vecs[2]  = '{1,0,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0, 1,1,8'h10,8'h5A, 0, 0,8'h00, 0,8'h00};
    vecs[3]  = '{1,0,0,8'h01,8'h00, 1,0,1,8'h02,8'h00, 1,1, 1,0,8'h10,8'h00, 0, 0,8'h00, 0,8'h00};
    vecs[4]  = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 1,0,8'h01,8'h00, 1, 0,8'h00, 0,8'h00};
    vecs[5]  = '{1,0,1,8'h20,8'h00, 1,0,1,8'h21,8'h00, 1,0, 0,0,8'h00,8'h00, 0, 1,8'h5A, 0,8'h00};
    vecs[6]  = '{1,0,1,8'h22,8'h00, 1,0,1,8'h21,8'h00, 0,1, 0,0,8'h00,8'h00, 1, 1,8'h31, 1,8'h82};
    vecs[7]  = '{1,0,1,8'h22,8'h00, 1,0,1,8'h23,8'h00, 1,0, 0,0,8'h00,8'h00, 1, 0,8'h31, 0,8'h82};
    vecs[8]  = '{1,0,1,8'h24,8'h00, 1,0,1,8'h23,8'h00, 0,1, 0,0,8'h00,8'h00, 1, 1,8'hA0, 0,8'h82};
    vecs[9]  = '{1,0,1,8'h24,8'h00, 0,0,0,8'h00,8'h00, 1,0, 0,0,8'h00,8'h00, 1, 0,8'hA0, 1,8'hA1};
    vecs[10] = '{0,0,0,8'h00,8'h00, 1,0,1,8'h03,8'h00, 0,1, 0,0,8'h00,8'h00, 1, 1,8'hA2, 0,8'hA1};
    vecs[11] = '{0,0,0,8'h00,8'h00, 1,0,1,8'h04,8'h00, 0,1, 0,0,8'h00,8'h00, 1, 0,8'hA2, 1,8'hA3};
    vecs[12] = '{0,0,0,8'h00,8'h00, 1,0,1,8'h05,8'h00, 0,1, 0,0,8'h00,8'h00, 1, 1,8'hA4, 0,8'hA3};
    vecs[13] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 0,0,8'h00,8'h00, 1, 0,8'hA4, 1,8'h83};
    vecs[14] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 0,0,8'h00,8'h00, 0, 0,8'hA4, 1,8'h84};
    vecs[15] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 0,0,8'h00,8'h00, 0, 0,8'hA4, 1,8'h85};
    vecs[16] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 0,0,8'h00,8'h00, 0, 0,8'hA4, 0,8'h85};

    // Reset with a request pending: ready must stay low, outputs at reset values
    drive(1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_r0_ready", 16'(bus.r0_ready), 16'h0);
    chk("rst_r1_ready", 16'(bus.r1_ready), 16'h0);
    chk("rst_mema_en",  16'(bus.mema_en), 16'h0);
    chk("rst_memb_addr", 16'(bus.memb_addr), 16'h0);
    chk("rst_r0_rdata", 16'(bus.r0_rdata), 16'h0);
    chk("rst_r1_rvalid", 16'(bus.r1_rvalid), 16'h0);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].we0, vecs[i].bk0, vecs[i].ad0, vecs[i].wd0,
            vecs[i].v1, vecs[i].we1, vecs[i].bk1, vecs[i].ad1, vecs[i].wd1);
      #1;
      $display("vec %0d: rdy=%b%b aen=%b ben=%b rv0=%b rd0=%h rv1=%b rd1=%h", i,
               bus.r0_ready, bus.r1_ready, bus.mema_en, bus.memb_en,
               bus.r0_rvalid, bus.r0_rdata, bus.r1_rvalid, bus.r1_rdata);
      chk($sformatf("v%0d_r0_ready", i), 16'(bus.r0_ready), 16'(vecs[i].rdy0));
      chk($sformatf("v%0d_r1_ready", i), 16'(bus.r1_ready), 16'(vecs[i].rdy1));
      chk($sformatf("v%0d_mema_en", i), 16'(bus.mema_en), 16'(vecs[i].aen));
      chk($sformatf("v%0d_mema_we", i), 16'(bus.mema_we), 16'(vecs[i].awe));
      if (vecs[i].aen) chk($sformatf("v%0d_mema_addr", i), 16'(bus.mema_addr), 16'(vecs[i].aaddr));
      if (vecs[i].awe) chk($sformatf("v%0d_mema_wdata", i), 16'(bus.mema_wdata), 16'(vecs[i].awdata));
      chk($sformatf("v%0d_memb_en", i), 16'(bus.memb_en), 16'(vecs[i].ben));
      chk($sformatf("v%0d_r0_rvalid", i), 16'(bus.r0_rvalid), 16'(vecs[i].rv0));
      chk($sformatf("v%0d_r0_rdata", i), 16'(bus.r0_rdata), 16'(vecs[i].rd0));
      chk($sformatf("v%0d_r1_rvalid", i), 16'(bus.r1_rvalid), 16'(vecs[i].rv1));
      chk($sformatf("v%0d_r1_rdata", i), 16'(bus.r1_rdata), 16'(vecs[i].rd1));
    end

`ifdef DMC_PERF_CNT_EN
    chk("cnt_conflict", cf_cnt, 16'd4);
    chk("cnt_r0_grant", r0_cnt, 16'd6);
    chk("cnt_r1_grant", r1_cnt, 16'd6);
    @(negedge clk);
    force dut.r_r0_grant_cnt = 16'hFFFE;
    #1;
    release dut.r_r0_grant_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1, 0, 8'(8'h40 + k), 8'h11, 0, 0, 0, 8'h00, 8'h00);
      #1;
      chk($sformatf("sat_ready%0d", k), 16'(bus.r0_ready), 16'h1);
      @(posedge clk);
      #1;
      chk($sformatf("sat_r0_cnt%0d", k), r0_cnt, 16'hFFFF);
      $display("sat accept %0d: r0_grant_cnt=%h", k, r0_cnt);
    end
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
`endif

    // Async reset while a bank-A read is in flight
    @(negedge clk);
    drive(1, 0, 0, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("inflight_ready", 16'(bus.r0_ready), 16'h1);
    @(negedge clk);
    drive(1, 1, 0, 8'h50, 8'h77, 1, 1, 0, 8'h51, 8'h88);
    #1;
    chk("inflight_mema_en", 16'(bus.mema_en), 16'h1);
    rst = 1'b1;
    #1;
    $display("async reset: mema_en=%b r0_rdata=%h r1_rdata=%h", bus.mema_en, bus.r0_rdata, bus.r1_rdata);
    chk("arst_mema_en", 16'(bus.mema_en), 16'h0);
    chk("arst_mema_addr", 16'(bus.mema_addr), 16'h0);
    chk("arst_memb_en", 16'(bus.memb_en), 16'h0);
    chk("arst_r0_rdata", 16'(bus.r0_rdata), 16'h0);
    chk("arst_r1_rdata", 16'(bus.r1_rdata), 16'h0);
    chk("arst_r0_ready", 16'(bus.r0_ready), 16'h0);
`ifdef DMC_PERF_CNT_EN
    chk("arst_r0_cnt", r0_cnt, 16'h0);
    chk("arst_cf_cnt", cf_cnt, 16'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_r0_ready", 16'(bus.r0_ready), 16'h1);
    chk("post_rst_r1_ready", 16'(bus.r1_ready), 16'h0);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h51, 8'h88);
    #1;
    chk("post_rst_r1_turn", 16'(bus.r1_ready), 16'h1);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("post_rst_r0_rvalid%0d", k), 16'(bus.r0_rvalid), 16'h0);
      chk($sformatf("post_rst_r1_rvalid%0d", k), 16'(bus.r1_rvalid), 16'h0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
